// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types for the alu_sequencer slice.
// Command kinds, FSM states and the latched command bundle.
package alu_seq_pkg;

  localparam int KIND_W = 2;
  localparam int OP_W   = 3;

  typedef enum logic [KIND_W-1:0] {
    KIND_EXEC  = 2'd0,
    KIND_LOADI = 2'd1,
    KIND_READ  = 2'd2,
    KIND_NOP   = 2'd3
  } cmd_kind_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Wait counter must hold ALU_LAT itself.
  function automatic int cnt_width(input int lat);
    if (lat < 2) return 1;
    return $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// alu_seq_regfile: operand register file for alu_sequencer.
// Two combinational read ports, one synchronous write port.
module alu_seq_regfile #(
  parameter int N              = 12,
  parameter int width_of_index = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      we,
  input  logic [width_of_index-1:0] waddr,
  input  logic [N-1:0]              wdata,
  input  logic [width_of_index-1:0] raddr1,
  input  logic [width_of_index-1:0] raddr2,
  output logic [N-1:0]              rdata1,
  output logic [N-1:0]              rdata2
);

  localparam int DEPTH = 1 << width_of_index;

  logic [N-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata1 = mem[raddr1];
  assign rdata2 = mem[raddr2];

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: command-driven controller for the shared alu.
// One command in flight; EXEC waits ALU_LAT edges after the ALU samples.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int N              = 12,
  parameter int width_of_index = 3,
  parameter int ALU_LAT        = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [1:0]                cmd_kind,
  input  logic [2:0]                cmd_op,
  input  logic [width_of_index-1:0] cmd_src1,
  input  logic [width_of_index-1:0] cmd_src2,
  input  logic [width_of_index-1:0] cmd_dst,
  input  logic [N-1:0]              cmd_imm,
  output logic [N-1:0]              alu_in1,
  output logic [N-1:0]              alu_in2,
  output logic [2:0]                alu_op,
  input  logic [N-1:0]              alu_out,
  output logic                      rsp_valid,
  output logic [N-1:0]              rsp_data,
  output logic                      zero_flag,
  output logic                      busy
);

  localparam int            CW     = cnt_width(ALU_LAT);
  localparam logic [CW-1:0] LAT_LD = CW'(ALU_LAT);

  state_t    state;
  state_t    state_nxt;
  cmd_kind_t kind;

  logic accept;
  logic take_exec;
  logic take_loadi;
  logic take_read;
  logic exec_done;

  logic [CW-1:0]             cnt;
  logic [width_of_index-1:0] dst_q;

  logic                      rf_we;
  logic [width_of_index-1:0] rf_waddr;
  logic [N-1:0]              rf_wdata;
  logic [N-1:0]              rf_rd1;
  logic [N-1:0]              rf_rd2;

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = ~cmd_ready;

  assign kind       = cmd_kind_t'(cmd_kind);
  assign accept     = cmd_valid & cmd_ready;
  assign take_exec  = accept & (kind == KIND_EXEC);
  assign take_loadi = accept & (kind == KIND_LOADI);
  assign take_read  = accept & (kind == KIND_READ);
  assign exec_done  = (state == ST_EXEC) & (cnt == '0);

  // LOADI and EXEC write-back never coincide: LOADI only lands in IDLE.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = cmd_dst;
    rf_wdata = cmd_imm;
    unique case (1'b1)
      exec_done: begin
        rf_we    = 1'b1;
        rf_waddr = dst_q;
        rf_wdata = alu_out;
      end
      take_loadi: begin
        rf_we = 1'b1;
      end
      default: ;
    endcase
  end

  alu_seq_regfile #(
    .N              (N),
    .width_of_index (width_of_index)
  ) u_rf (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (rf_we),
    .waddr  (rf_waddr),
    .wdata  (rf_wdata),
    .raddr1 (cmd_src1),
    .raddr2 (cmd_src2),
    .rdata1 (rf_rd1),
    .rdata2 (rf_rd2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      (state == ST_IDLE): begin
        unique case (1'b1)
          take_exec:  state_nxt = ST_EXEC;
          take_loadi: state_nxt = ST_RESP;
          take_read:  state_nxt = ST_RESP;
          default: ;
        endcase
      end
      (state == ST_EXEC): begin
        if (exec_done) begin
          state_nxt = ST_RESP;
        end
      end
      (state == ST_RESP): begin
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operands hold outside EXEC so the ALU sees stable inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_in1 <= '0;
      alu_in2 <= '0;
      alu_op  <= '0;
      dst_q   <= '0;
    end else if (take_exec) begin
      alu_in1 <= rf_rd1;
      alu_in2 <= rf_rd2;
      alu_op  <= cmd_op;
      dst_q   <= cmd_dst;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (take_exec) begin
      cnt <= LAT_LD;
    end else if ((state == ST_EXEC) && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      zero_flag <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (1'b1)
        exec_done: begin
          rsp_valid <= 1'b1;
          rsp_data  <= alu_out;
          zero_flag <= (alu_out == '0);
        end
        take_loadi: begin
          rsp_valid <= 1'b1;
          rsp_data  <= cmd_imm;
          zero_flag <= (cmd_imm == '0);
        end
        take_read: begin
          rsp_valid <= 1'b1;
          rsp_data  <= rf_rd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed bench for alu_sequencer at ALU_LAT 1 and 3.
// A transaction-level model predicts every output each cycle.
module tb_alu_sequencer;

  localparam logic [1:0] K_EXEC  = 2'd0;
  localparam logic [1:0] K_LOADI = 2'd1;
  localparam logic [1:0] K_READ  = 2'd2;
  localparam logic [1:0] K_NOP   = 2'd3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int ndone    = 0;

  function automatic logic [11:0] alu_ref(
    input logic [2:0]  op,
    input logic [11:0] a,
    input logic [11:0] b
  );
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ~a;
      3'd6:    return a;
      default: return b;
    endcase
  endfunction

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int LAT = (g == 0) ? 1 : 3;

    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_kind;
    logic [2:0]  cmd_op;
    logic [2:0]  cmd_src1;
    logic [2:0]  cmd_src2;
    logic [2:0]  cmd_dst;
    logic [11:0] cmd_imm;
    logic [11:0] alu_in1;
    logic [11:0] alu_in2;
    logic [2:0]  alu_op;
    logic [11:0] alu_out;
    logic        rsp_valid;
    logic [11:0] rsp_data;
    logic        zero_flag;
    logic        busy;

    alu_sequencer #(
      .N              (12),
      .width_of_index (3),
      .ALU_LAT        (LAT)
    ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_kind  (cmd_kind),
      .cmd_op    (cmd_op),
      .cmd_src1  (cmd_src1),
      .cmd_src2  (cmd_src2),
      .cmd_dst   (cmd_dst),
      .cmd_imm   (cmd_imm),
      .alu_in1   (alu_in1),
      .alu_in2   (alu_in2),
      .alu_op    (alu_op),
      .alu_out   (alu_out),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .zero_flag (zero_flag),
      .busy      (busy)
    );

    // External ALU: LAT register stages behind its operand inputs.
    logic [11:0] pipe [LAT];
    always @(posedge clk) begin
      pipe[0] <= alu_ref(alu_op, alu_in1, alu_in2);
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign alu_out = pipe[LAT-1];

    logic        s_rst;
    logic        s_valid;
    logic [1:0]  s_kind;
    logic [2:0]  s_op;
    logic [2:0]  s_s1;
    logic [2:0]  s_s2;
    logic [2:0]  s_dst;
    logic [11:0] s_imm;

    always @(posedge clk) begin
      s_rst   <= rst_n;
      s_valid <= cmd_valid;
      s_kind  <= cmd_kind;
      s_op    <= cmd_op;
      s_s1    <= cmd_src1;
      s_s2    <= cmd_src2;
      s_dst   <= cmd_dst;
      s_imm   <= cmd_imm;
    end

    logic [11:0] mrf [8];
    logic [11:0] mdata, min1, min2, res;
    logic [2:0]  mop, pend_dst;
    logic        mzero, mvalid, pend;
    int          cyc, busy_till, pend_at;
    logic        run = 1'b0;
    string       p;

    // Model: one step per edge; interval k lies between edge k and k+1.
    always @(negedge clk) begin
      if (rst_n !== 1'b1 || s_rst !== 1'b1) begin
        for (int i = 0; i < 8; i++) mrf[i] = '0;
        mdata = '0; min1 = '0; min2 = '0; mop = '0;
        mzero = 1'b0; mvalid = 1'b0; pend = 1'b0;
        cyc = 0; busy_till = -1; pend_at = 0; pend_dst = '0;
      end else begin
        cyc++;
        mvalid = 1'b0;
        if (s_valid && (cyc - 1 > busy_till)) begin
          case (s_kind)
            K_EXEC: begin
              min1 = mrf[s_s1];
              min2 = mrf[s_s2];
              mop = s_op;
              pend = 1'b1;
              pend_at = cyc + 1 + LAT;
              pend_dst = s_dst;
              busy_till = cyc + 1 + LAT;
            end
            K_LOADI: begin
              mrf[s_dst] = s_imm;
              mdata = s_imm;
              mzero = (s_imm == 12'd0);
              mvalid = 1'b1;
              busy_till = cyc;
            end
            K_READ: begin
              mdata = mrf[s_s1];
              mvalid = 1'b1;
              busy_till = cyc;
            end
            default: ;
          endcase
        end
        if (pend && cyc == pend_at) begin
          res = alu_ref(mop, min1, min2);
          mrf[pend_dst] = res;
          mdata = res;
          mzero = (res == 12'd0);
          mvalid = 1'b1;
          pend = 1'b0;
        end
      end
      if (run) begin
        p = $sformatf("lat%0d", LAT);
        chk({p, " cmd_ready"}, cmd_ready, cyc > busy_till);
        chk({p, " busy"}, busy, !(cyc > busy_till));
        chk({p, " rsp_valid"}, rsp_valid, mvalid);
        chk({p, " rsp_data"}, rsp_data, mdata);
        chk({p, " zero_flag"}, zero_flag, mzero);
        chk({p, " alu_in1"}, alu_in1, min1);
        chk({p, " alu_in2"}, alu_in2, min2);
        chk({p, " alu_op"}, alu_op, mop);
      end
    end

    // Call just after a negedge; returns at the negedge after acceptance.
    task automatic send(
      input logic [1:0]  k,
      input logic [2:0]  op,
      input logic [2:0]  s1,
      input logic [2:0]  s2,
      input logic [2:0]  d,
      input logic [11:0] im
    );
      int n = 0;
      cmd_kind = k; cmd_op = op;
      cmd_src1 = s1; cmd_src2 = s2;
      cmd_dst = d; cmd_imm = im;
      cmd_valid = 1'b1;
      while (cmd_ready !== 1'b1 && n < 40) begin
        @(negedge clk);
        n++;
      end
      if (n >= 40) begin
        checks++;
        failures++;
        $display("FAIL lat%0d accept_timeout: got busy expected ready", LAT);
      end
      @(negedge clk);
    endtask

    task automatic lit(input string nm, input logic [31:0] a, input logic [31:0] e);
      chk($sformatf("lat%0d %s", LAT, nm), a, e);
    endtask

    initial begin
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_kind = '0; cmd_op = '0;
      cmd_src1 = '0; cmd_src2 = '0; cmd_dst = '0; cmd_imm = '0;
      repeat (3) @(negedge clk);
      run = 1'b1;
      @(negedge clk);
      lit("reset ready", cmd_ready, 1);
      lit("reset data", rsp_data, 0);
      #1 rst_n = 1'b1;
      @(negedge clk);

      send(K_LOADI, 0, 0, 0, 1, 12'd5);
      cmd_valid = 1'b0;
      lit("loadi r1 valid", rsp_valid, 1);
      lit("loadi r1 data", rsp_data, 5);
      @(negedge clk);
      lit("loadi one cycle", rsp_valid, 0);
      send(K_LOADI, 0, 0, 0, 2, 12'd10);
      cmd_valid = 1'b0;
      @(negedge clk);
      send(K_READ, 0, 1, 0, 0, 12'd0);
      cmd_valid = 1'b0;
      lit("read r1", rsp_data, 5);
      @(negedge clk);

      send(K_EXEC, 3'd0, 1, 2, 3, 12'd0);
      cmd_valid = 1'b0;
      lit("add in1", alu_in1, 5);
      lit("add in2", alu_in2, 10);
      lit("add op", alu_op, 0);
      repeat (1 + LAT) @(negedge clk);
      lit("add valid", rsp_valid, 1);
      lit("add data", rsp_data, 15);
      @(negedge clk);
      send(K_READ, 0, 3, 0, 0, 12'd0);
      cmd_valid = 1'b0;
      lit("read r3", rsp_data, 15);
      lit("zero after add", zero_flag, 0);
      @(negedge clk);

      send(K_LOADI, 0, 0, 0, 1, 12'd10);
      cmd_valid = 1'b0;
      @(negedge clk);
      send(K_EXEC, 3'd1, 1, 2, 5, 12'd0);
      cmd_valid = 1'b0;
      repeat (1 + LAT) @(negedge clk);
      lit("sub data", rsp_data, 0);
      lit("sub zero", zero_flag, 1);
      @(negedge clk);
      send(K_READ, 0, 3, 0, 0, 12'd0);
      cmd_valid = 1'b0;
      lit("read keeps zero", zero_flag, 1);
      @(negedge clk);
      send(K_LOADI, 0, 0, 0, 4, 12'd7);
      cmd_valid = 1'b0;
      lit("loadi clears zero", zero_flag, 0);
      @(negedge clk);

      send(K_LOADI, 0, 0, 0, 6, 12'h123);
      send(K_EXEC, 3'd0, 6, 4, 7, 12'd0);
      send(K_NOP, 0, 0, 0, 0, 12'hfff);
      send(K_EXEC, 3'd4, 7, 6, 7, 12'd0);
      send(K_READ, 0, 7, 0, 0, 12'd0);
      send(K_LOADI, 0, 0, 0, 0, 12'd0);
      send(K_EXEC, 3'd5, 0, 0, 2, 12'd0);
      cmd_valid = 1'b0;
      repeat (LAT + 3) @(negedge clk);
      send(K_READ, 0, 7, 0, 0, 12'd0);
      cmd_valid = 1'b0;
      lit("read r7 xor", rsp_data, 12'h009);
      @(negedge clk);
      send(K_READ, 0, 2, 0, 0, 12'd0);
      cmd_valid = 1'b0;
      lit("read r2 not", rsp_data, 12'hfff);
      @(negedge clk);

      send(K_EXEC, 3'd0, 1, 2, 3, 12'd0);
      cmd_valid = 1'b0;
      #1 rst_n = 1'b0;
      @(negedge clk);
      lit("midrst ready", cmd_ready, 1);
      lit("midrst in1", alu_in1, 0);
      lit("midrst data", rsp_data, 0);
      #1 rst_n = 1'b1;
      repeat (LAT + 3) @(negedge clk);
      send(K_READ, 0, 3, 0, 0, 12'd0);
      cmd_valid = 1'b0;
      lit("read r3 after reset", rsp_data, 0);
      lit("valid after reset", rsp_valid, 1);
      repeat (3) @(negedge clk);
      ndone++;
    end
  end

  initial begin
    fork
      wait (ndone == 2);
      #100000;
    join_any
    disable fork;
    if (ndone != 2) begin
      failures++;
      $display("FAIL run_timeout: got %0d done expected 2", ndone);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
